ssd_scan_driver: RTL and testbench

- Multiplexed 4-digit seven-segment driver, downstream of the Hack CPU top.
- Consumes the D-register value and the decoder's display strobe (`dis`).
- Latches the value into a shadow register, optionally converts it to BCD, and time-multiplexes the four digits onto shared segment lines and anode enables (Basys3-style board).

---
 rtl/ssd_pkg.sv | 34 +++
 rtl/ssd_scan_driver_if.sv | 15 +
 rtl/bin2bcd_seq.sv | 72 +++++++
 rtl/ssd_scan_driver.sv | 91 +++++++++
 tb/tb_ssd_scan_driver.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ssd_pkg.sv
// Shared constants and glyph table for the multiplexed seven-segment scan driver.
package ssd_pkg;

    localparam int DIGITS    = 4;
    localparam int BCD_ITERS = 16;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/ssd_scan_driver_if.sv
// Capture handshake and display lines between the CPU side and the scan driver.
interface ssd_scan_driver_if;
    import ssd_pkg::*;

    logic [15:0]       data_in;
    logic              load;
    logic              busy;
    logic [6:0]        seg;
    logic [DIGITS-1:0] an;
    logic              dp;

    modport master (output data_in, load, input busy, seg, an, dp);
    modport slave  (input data_in, load, output busy, seg, an, dp);

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one shift/add-3 step per cycle, result valid with done.
// state  | meaning
// S_IDLE | waiting for start
// S_CONV | shifting, iteration count in iter
module bin2bcd_seq
    import ssd_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] bin_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] bcd_out,
    output logic        ovr_out
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_CONV = 1'b1;

    logic [0:0]  state;
    logic [3:0]  iter;
    logic [15:0] bin_r;
    logic [15:0] bcd_r;
    logic [15:0] bcd_adj;
    logic        ovr_r;

    always_comb begin
        bcd_adj = bcd_r;
        for (int d = 0; d < 4; d++) begin
            if (bcd_r[d*4 +: 4] >= 4'd5)
                bcd_adj[d*4 +: 4] = bcd_r[d*4 +: 4] + 4'd3;
        end
    end

    // The final step's result is forwarded combinationally so the caller can
    // commit it on the same edge busy falls.
    assign bcd_out = {bcd_adj[14:0], bin_r[15]};
    assign busy    = (state == S_CONV);
    assign done    = (state == S_CONV) && (iter == 4'(BCD_ITERS - 1));
    assign ovr_out = ovr_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            iter  <= '0;
            bin_r <= '0;
            bcd_r <= '0;
            ovr_r <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        bin_r <= bin_in;
                        bcd_r <= '0;
                        iter  <= '0;
                        ovr_r <= (bin_in > 16'd9999);
                        state <= S_CONV;
                    end
                end
                default: begin
                    bcd_r <= bcd_out;
                    bin_r <= {bin_r[14:0], 1'b0};
                    iter  <= iter + 4'd1;
                    if (done)
                        state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/ssd_scan_driver.sv
// Four-digit multiplexed seven-segment driver fed by the CPU's D register.
// Define SSD_BCD_EN for decimal display through a sequential binary-to-BCD converter.
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int CNT_W       = 17
)
(
    input  logic           clk,
    input  logic           reset,
    ssd_scan_driver_if.slave bus
);

    logic [CNT_W-1:0]  cnt;
    logic [1:0]        idx;
    logic [15:0]       shadow;
    logic              ovr_r;
    logic [6:0]        seg_r;
    logic [DIGITS-1:0] an_r;
    logic              dp_r;

`ifdef SSD_BCD_EN
    logic        load_q;
    logic        start;
    logic        conv_busy;
    logic        conv_done;
    logic        conv_ovr;
    logic [15:0] conv_bcd;

    // A held load starts only one conversion.
    assign start = bus.load && !load_q && !conv_busy;

    bin2bcd_seq u_conv (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .bin_in  (bus.data_in),
        .busy    (conv_busy),
        .done    (conv_done),
        .bcd_out (conv_bcd),
        .ovr_out (conv_ovr)
    );

    assign bus.busy = conv_busy;
`else
    assign bus.busy = 1'b0;
`endif

    assign bus.seg = seg_r;
    assign bus.an  = an_r;
    assign bus.dp  = dp_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            idx    <= '0;
            shadow <= '0;
            ovr_r  <= 1'b0;
            seg_r  <= SEG_BLANK;
            an_r   <= '1;
            dp_r   <= 1'b1;
`ifdef SSD_BCD_EN
            load_q <= 1'b0;
`endif
        end else begin
            if (cnt == CNT_W'(REFRESH_DIV - 1)) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            an_r  <= ~(DIGITS'(1) << idx);
            seg_r <= ovr_r ? SEG_DASH : hex_to_seg(shadow[{idx, 2'b00} +: 4]);
            dp_r  <= 1'b1;

`ifdef SSD_BCD_EN
            load_q <= bus.load;
            if (conv_done) begin
                shadow <= conv_bcd;
                ovr_r  <= conv_ovr;
            end
`else
            if (bus.load)
                shadow <= bus.data_in;
`endif
        end
    end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Directed bench for ssd_scan_driver with a 4-cycle digit dwell.
module tb_ssd_scan_driver;

    logic clk;
    logic reset;
    int   cmp_cnt;
    int   err_cnt;
    int   ecount;

    ssd_scan_driver_if bus();

    ssd_scan_driver #(.REFRESH_DIV(4), .CNT_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then return at the falling edge where outputs are sampled.
    task automatic step();
        @(posedge clk);
        ecount++;
        @(negedge clk);
    endtask

    function automatic int scan_idx(input int e);
        return ((e - 1) / 4) % 4;
    endfunction

    function automatic logic [3:0] an_for(input int d);
        logic [3:0] one;
        one = 4'b0001 << d;
        return ~one;
    endfunction

    task automatic goto_digit(input int d);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while ((scan_idx(ecount) != d) && (n < 20));
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.load = 1'b0;
        bus.data_in = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            step();
            cmp_cnt++;
            if (bus.seg !== 7'h7F || bus.an !== 4'hF || bus.busy !== 1'b0) begin
                err_cnt++;
                $display("FAIL reset_hold cyc%0d: seg=%h an=%b busy=%b, want seg=7f an=1111 busy=0", i, bus.seg, bus.an, bus.busy);
            end
        end
        reset = 1'b0;
        ecount = 0;
        step();
        cmp_cnt++;
        if (bus.an !== 4'b1110 || bus.seg !== 7'h40 || bus.dp !== 1'b1) begin
            err_cnt++;
            $display("FAIL first_after_release: an=%b seg=%h dp=%b, want an=1110 seg=40 dp=1", bus.an, bus.seg, bus.dp);
        end
        for (int i = 0; i < 16; i++) begin
            step();
            cmp_cnt++;
            if (bus.an !== an_for(scan_idx(ecount)) || bus.seg !== 7'h40) begin
                err_cnt++;
                $display("FAIL scan_rotation edge%0d: an=%b seg=%h, want an=%b seg=40", ecount, bus.an, bus.seg, an_for(scan_idx(ecount)));
            end
        end
    endtask

`ifndef SSD_BCD_EN
    task automatic test_hex_load();
        logic [6:0] exp_seg [4];
        exp_seg[0] = 7'h40; exp_seg[1] = 7'h0E; exp_seg[2] = 7'h30; exp_seg[3] = 7'h08;
        bus.data_in = 16'hA3F0;
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        for (int d = 0; d < 4; d++) begin
            goto_digit(d);
            cmp_cnt++;
            if (bus.an !== an_for(d) || bus.seg !== exp_seg[d] || bus.dp !== 1'b1 || bus.busy !== 1'b0) begin
                err_cnt++;
                $display("FAIL hex_A3F0 digit%0d: an=%b seg=%h dp=%b busy=%b, want an=%b seg=%h dp=1 busy=0",
                         d, bus.an, bus.seg, bus.dp, bus.busy, an_for(d), exp_seg[d]);
            end
        end
    endtask

    task automatic test_load_on_wrap();
        logic [6:0] exp_seg [4];
        exp_seg[0] = 7'h19; exp_seg[1] = 7'h30; exp_seg[2] = 7'h24; exp_seg[3] = 7'h79;
        for (int n = 0; n < 20 && ((ecount + 1) % 16) != 4; n++) step();
        bus.data_in = 16'h1234;
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        bus.data_in = 16'hFFFF;
        step();
        cmp_cnt++;
        if (bus.an !== 4'b1101 || bus.seg !== 7'h30) begin
            err_cnt++;
            $display("FAIL load_on_wrap: an=%b seg=%h, want an=1101 seg=30", bus.an, bus.seg);
        end
        for (int d = 2; d < 6; d++) begin
            goto_digit(d % 4);
            cmp_cnt++;
            if (bus.an !== an_for(d % 4) || bus.seg !== exp_seg[d % 4]) begin
                err_cnt++;
                $display("FAIL hex_1234 digit%0d: an=%b seg=%h, want an=%b seg=%h",
                         d % 4, bus.an, bus.seg, an_for(d % 4), exp_seg[d % 4]);
            end
        end
    endtask

    task automatic test_held_load();
        bus.load = 1'b1;
        bus.data_in = 16'h1111; step();
        bus.data_in = 16'h2222; step();
        bus.data_in = 16'h5555; step();
        bus.load = 1'b0;
        step();
        cmp_cnt++;
        if (bus.seg !== 7'h12) begin
            err_cnt++;
            $display("FAIL held_load_recapture: seg=%h, want 12", bus.seg);
        end
    endtask
`else
    task automatic test_bcd_9876();
        logic [6:0] exp_seg [4];
        exp_seg[0] = 7'h02; exp_seg[1] = 7'h78; exp_seg[2] = 7'h00; exp_seg[3] = 7'h10;
        bus.data_in = 16'd9876;
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            cmp_cnt++;
            if (bus.busy !== (c <= 16) || bus.seg !== 7'h40) begin
                err_cnt++;
                $display("FAIL bcd_busy_hold cyc%0d: busy=%b seg=%h, want busy=%b seg=40", c, bus.busy, bus.seg, (c <= 16));
            end
            if (c == 4) begin
                bus.data_in = 16'd1;
                bus.load = 1'b1;
            end else begin
                bus.load = 1'b0;
            end
            if (c < 17) step();
        end
        for (int d = 0; d < 4; d++) begin
            goto_digit(d);
            cmp_cnt++;
            if (bus.an !== an_for(d) || bus.seg !== exp_seg[d]) begin
                err_cnt++;
                $display("FAIL bcd_9876 digit%0d: an=%b seg=%h, want an=%b seg=%h", d, bus.an, bus.seg, an_for(d), exp_seg[d]);
            end
        end
        cmp_cnt++;
        if (bus.busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL bcd_drop_queued: busy=%b, want 0", bus.busy);
        end
    endtask

    task automatic test_bcd_range();
        bus.data_in = 16'd10000;
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        for (int i = 0; i < 16; i++) step();
        cmp_cnt++;
        if (bus.busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL bcd_ovr_busy: busy=%b, want 0", bus.busy);
        end
        for (int d = 0; d < 4; d++) begin
            goto_digit(d);
            cmp_cnt++;
            if (bus.an !== an_for(d) || bus.seg !== 7'h3F) begin
                err_cnt++;
                $display("FAIL bcd_ovr digit%0d: an=%b seg=%h, want an=%b seg=3f", d, bus.an, bus.seg, an_for(d));
            end
        end
        bus.data_in = 16'd0;
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        for (int i = 0; i < 16; i++) step();
        for (int d = 0; d < 4; d++) begin
            goto_digit(d);
            cmp_cnt++;
            if (bus.an !== an_for(d) || bus.seg !== 7'h40) begin
                err_cnt++;
                $display("FAIL bcd_zero digit%0d: an=%b seg=%h, want an=%b seg=40", d, bus.an, bus.seg, an_for(d));
            end
        end
    endtask

    task automatic test_reset_abort();
        bus.data_in = 16'd4321;
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        for (int i = 2; i < 8; i++) step();
        reset = 1'b1;
        step();
        cmp_cnt++;
        if (bus.busy !== 1'b0 || bus.seg !== 7'h7F || bus.an !== 4'hF) begin
            err_cnt++;
            $display("FAIL reset_abort: busy=%b seg=%h an=%b, want busy=0 seg=7f an=1111", bus.busy, bus.seg, bus.an);
        end
        reset = 1'b0;
        ecount = 0;
        for (int i = 0; i < 24; i++) begin
            step();
            cmp_cnt++;
            if (bus.seg !== 7'h40 || bus.busy !== 1'b0 || bus.an !== an_for(scan_idx(ecount))) begin
                err_cnt++;
                $display("FAIL after_abort edge%0d: seg=%h busy=%b an=%b, want seg=40 busy=0 an=%b",
                         ecount, bus.seg, bus.busy, bus.an, an_for(scan_idx(ecount)));
            end
        end
    endtask
`endif

    initial begin
        cmp_cnt = 0;
        err_cnt = 0;
        ecount = 0;
        test_reset();
`ifndef SSD_BCD_EN
        test_hex_load();
        test_load_on_wrap();
        test_held_load();
`else
        test_bcd_9876();
        test_bcd_range();
        test_reset_abort();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
